tpu_window_feeder: RTL

TPU_WINDOW_FEEDER -- requirements
Module: tpu_window_feeder

---
 rtl/tpu_window_feeder.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/tpu_window_feeder.sv
// Turns a raster pixel stream into stride-1 KxK windows (valid padding) for the systolic array.
// Latency 1 from the generating pixel; a held window stalls pix_ready, and the final window of a frame blocks the next frame.
module tpu_window_feeder #(
  parameter int dataSize    = 8,
  parameter int kernelWidth = 3,
  parameter int imgWidth    = 8,
  parameter int imgHeight   = 8
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic [dataSize-1:0] pix_in,
  input  logic                pix_valid,
  output logic                pix_ready,
  output logic [dataSize-1:0] window_out [0:kernelWidth*kernelWidth-1],
  output logic                window_valid,
  input  logic                window_ready,
  output logic                frame_done
);

  localparam int K    = kernelWidth;
  localparam int W    = imgWidth;
  localparam int H    = imgHeight;
  localparam int NPEY = K * K;
  localparam int NB   = K - 1;
  localparam int CW   = (W > 1) ? $clog2(W) : 1;
  localparam int RW   = (H > 1) ? $clog2(H) : 1;
  localparam int SW   = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    ACTIVE = 2'd1,
    LAST   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       col_q, col_d;
  logic [RW-1:0]       row_q, row_d;
  logic [SW-1:0]       sel_q, sel_d;
  logic                window_valid_q, window_valid_d;
  logic [dataSize-1:0] window_out_q [0:NPEY-1];
  logic [dataSize-1:0] window_out_d [0:NPEY-1];
  logic [dataSize-1:0] win_q [0:K-1][0:K-1];
  logic [dataSize-1:0] win_d [0:K-1][0:K-1];

  // Line buffers are used round-robin: slot sel_q holds the oldest stored row,
  // which is read for the current window column and then overwritten in place.
  logic [dataSize-1:0] lb_q [0:NB-1][0:W-1];
  logic [dataSize-1:0] col_vals [0:K-1];
  logic [SW:0]         rd_idx [0:NB-1];

  logic pix_acc;
  logic win_acc;
  logic at_eol;
  logic at_eof;
  logic gen;

  assign pix_ready    = !window_valid_q || window_ready;
  assign pix_acc      = pix_valid && pix_ready;
  assign win_acc      = window_valid_q && window_ready;
  assign at_eol       = (col_q == CW'(W - 1));
  assign at_eof       = at_eol && (row_q == RW'(H - 1));
  assign gen          = pix_acc && (row_q >= RW'(K - 1)) && (col_q >= CW'(K - 1));
  assign window_valid = window_valid_q;
  assign window_out   = window_out_q;
  assign frame_done   = (state_q == LAST) && win_acc;

  // Vertical slice of the window at the current column, oldest row first.
  always_comb begin
    for (int j = 0; j < NB; j++) begin
      rd_idx[j] = {1'b0, sel_q} + (SW+1)'(j);
      if (rd_idx[j] >= (SW+1)'(NB)) begin
        rd_idx[j] = rd_idx[j] - (SW+1)'(NB);
      end
      col_vals[j] = lb_q[rd_idx[j][SW-1:0]][col_q];
    end
    col_vals[K-1] = pix_in;
  end

  always_comb begin
    win_d          = win_q;
    window_out_d   = window_out_q;
    window_valid_d = window_valid_q;
    if (pix_acc) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) begin
          win_d[r][c] = win_q[r][c+1];
        end
        win_d[r][K-1] = col_vals[r];
      end
    end
    if (win_acc) begin
      window_valid_d = 1'b0;
    end
    if (gen) begin
      window_valid_d = 1'b1;
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          window_out_d[r*K+c] = win_d[r][c];
        end
      end
    end
  end

  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    sel_d   = sel_q;
    state_d = state_q;
    if (pix_acc) begin
      if (at_eol) begin
        col_d = '0;
        if (at_eof) begin
          row_d = '0;
          sel_d = '0;
        end else begin
          row_d = row_q + 1'b1;
          sel_d = (sel_q == SW'(NB - 1)) ? '0 : sel_q + 1'b1;
        end
      end else begin
        col_d = col_q + 1'b1;
      end
    end
    case (state_q)
      FILL: begin
        if (pix_acc && at_eol && (row_q == RW'(K - 2))) begin
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (pix_acc && at_eof) begin
          state_d = LAST;
        end
      end
      LAST: begin
        if (win_acc) begin
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q        <= FILL;
      col_q          <= '0;
      row_q          <= '0;
      sel_q          <= '0;
      window_valid_q <= 1'b0;
      for (int k = 0; k < NPEY; k++) begin
        window_out_q[k] <= '0;
      end
    end else begin
      state_q        <= state_d;
      col_q          <= col_d;
      row_q          <= row_d;
      sel_q          <= sel_d;
      window_valid_q <= window_valid_d;
      window_out_q   <= window_out_d;
    end
  end

  // Pixel storage is always overwritten before it is read, so it carries no reset.
  always_ff @(posedge clk) begin
    win_q <= win_d;
    if (pix_acc) begin
      lb_q[sel_q][col_q] <= pix_in;
    end
  end

endmodule
